// File: rtl/mtr_drv.sv
// Two-sided H-bridge PWM stage: latches signed speed commands at PWM period boundaries and
// inserts one fully-dead period on each direction reversal. Optional macro: SLEW_LIMIT_EN.
module mtr_drv #(
    parameter int PWM_W     = 11,
    parameter int SLEW_STEP = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    output logic        PWM_lft_fwd,
    output logic        PWM_lft_rev,
    output logic        PWM_rght_fwd,
    output logic        PWM_rght_rev,
    output logic        period_done
);

    typedef enum logic [1:0] {
        FWD    = 2'd0,
        REV    = 2'd1,
        DEAD_F = 2'd2,
        DEAD_R = 2'd3
    } side_state_e;

    localparam int CMP_W = (PWM_W > 11) ? PWM_W : 11;

    logic [PWM_W-1:0]   cnt_q, cnt_d;
    logic               boundary;
    side_state_e        state_q [2];
    side_state_e        state_d [2];
    logic signed [11:0] spd_q [2];
    logic signed [11:0] spd_d [2];
    logic signed [11:0] cmd [2];
    logic [1:0]         fwd_q, fwd_d, rev_q, rev_d;

    // -2048 has no positive 12-bit counterpart, so it saturates to the largest duty.
    function automatic logic [10:0] mag_of(input logic signed [11:0] s);
        if (s == 12'sh800) mag_of = 11'h7FF;
        else if (s[11])    mag_of = 11'(-s);
        else               mag_of = s[10:0];
    endfunction

    function automatic logic signed [11:0] slew(input logic signed [11:0] cur,
                                                input logic signed [11:0] tgt);
        logic signed [12:0] diff, step, nxt;
        step = 13'(SLEW_STEP);
        diff = {tgt[11], tgt} - {cur[11], cur};
        if (diff > step)       nxt = {cur[11], cur} + step;
        else if (diff < -step) nxt = {cur[11], cur} - step;
        else                   nxt = {tgt[11], tgt};
        if (nxt > 13'sd2047)       slew = 12'sh7FF;
        else if (nxt < -13'sd2048) slew = 12'sh800;
        else                       slew = nxt[11:0];
    endfunction

    assign cmd[0]      = lft_spd;
    assign cmd[1]      = rght_spd;
    assign boundary    = &cnt_q;
    assign period_done = boundary;

    // Outputs are registered from the next-state values so cycle cnt=c shows (c < mag).
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        fwd_d = '0;
        rev_d = '0;
        for (int i = 0; i < 2; i++) begin
            spd_d[i]   = spd_q[i];
            state_d[i] = state_q[i];
            if (!en) begin
                spd_d[i]   = '0;
                state_d[i] = FWD;
            end else if (boundary) begin
`ifdef SLEW_LIMIT_EN
                spd_d[i] = slew(spd_q[i], cmd[i]);
`else
                spd_d[i] = cmd[i];
`endif
                unique case (state_q[i])
                    FWD:    if (spd_d[i][11]) state_d[i] = DEAD_R;
                    REV:    if (!spd_d[i][11] && (spd_d[i] != '0)) state_d[i] = DEAD_F;
                    DEAD_F: state_d[i] = spd_d[i][11] ? REV : FWD;
                    DEAD_R: state_d[i] = (!spd_d[i][11] && (spd_d[i] != '0)) ? FWD : REV;
                    default: state_d[i] = FWD;
                endcase
            end
            fwd_d[i] = en && (state_d[i] == FWD) &&
                       (CMP_W'(cnt_d) < CMP_W'(mag_of(spd_d[i])));
            rev_d[i] = en && (state_d[i] == REV) &&
                       (CMP_W'(cnt_d) < CMP_W'(mag_of(spd_d[i])));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            fwd_q <= '0;
            rev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                spd_q[i]   <= '0;
                state_q[i] <= FWD;
            end
        end else begin
            cnt_q <= cnt_d;
            fwd_q <= fwd_d;
            rev_q <= rev_d;
            for (int i = 0; i < 2; i++) begin
                spd_q[i]   <= spd_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign PWM_lft_fwd  = fwd_q[0];
    assign PWM_lft_rev  = rev_q[0];
    assign PWM_rght_fwd = fwd_q[1];
    assign PWM_rght_rev = rev_q[1];

endmodule

// File: doc/mtr_drv.md
Name: mtr_drv

Overview:
- Motor drive stage directly downstream of the PID block. Consumes the 12-bit left/right speed commands and produces per-side H-bridge PWM pairs (forward/reverse).
- A dead period is inserted on every direction reversal, so the forward and reverse legs of one side are never high together.
- Duty and direction update only at PWM period boundaries, which keeps the outputs glitch-free.

Parameters:
- PWM_W, 11: PWM counter width; period = 2^PWM_W clocks (2048 at default).
- SLEW_STEP, 64: max change of the latched speed per period (used only with SLEW_LIMIT_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  drive enable (driven by go); low = coast
- lft_spd  in  12  signed left speed command (two's complement)
- rght_spd  in  12  signed right speed command
- PWM_lft_fwd  out  1  left forward leg
- PWM_lft_rev  out  1  left reverse leg
- PWM_rght_fwd  out  1  right forward leg
- PWM_rght_rev  out  1  right reverse leg
- period_done  out  1  one-cycle pulse when the counter is at its maximum

Behaviour:
- Reset: cnt=0, both spd_q=0, both side FSMs=FWD, all PWM outputs 0, period_done=0.
- cnt is a free-running PWM_W-bit up-counter that wraps from all-ones to 0. It is unaffected by en.
- Boundary: cnt == all-ones. At the boundary:
  - period_done=1 for that single cycle.
  - Each side samples its command: spd_q <= spd (or the slewed value, see Optional Feature).
- Latency: a command sampled at a boundary affects the outputs from the next cycle (cnt=0). Command changes mid-period are ignored until the next boundary.
- Magnitude: mag = |spd_q|, 11 bits. spd_q = -2048 saturates to mag 2047.
- Duty: the active leg is high while cnt < mag.
  - mag=0: leg always low.
  - mag=2047: leg high for 2047 of 2048 cycles.
- Outputs are registered from cnt and the state/magnitude registers, so no combinational glitches.
- Per-side FSM, states FWD, REV, DEAD_F, DEAD_R:
  - FWD: fwd leg = PWM, rev = 0.
  - REV: rev leg = PWM, fwd = 0.
  - DEAD_x: both legs 0 for one full period.
  - Transitions are evaluated only at the boundary, using the newly latched spd_q.
  - FWD -> DEAD_R if spd_q < 0. REV -> DEAD_F if spd_q > 0.
  - spd_q == 0 never triggers a reversal; the current state is kept.
  - DEAD_x, at the next boundary: go to FWD if spd_q > 0, REV if spd_q < 0. If spd_q == 0, go to the pending direction x.
  - A reversal therefore costs exactly one fully-dead period.
- en low (synchronous, checked every cycle):
  - All four legs go low from the next cycle.
  - spd_q is cleared to 0 and both FSMs are forced to FWD.
  - Sampling at boundaries is suppressed; cnt keeps running.
- en rising: normal operation resumes. The first command is taken at the next boundary.
- Invariant: fwd and rev of the same side are never both 1, in any cycle, including around reset and en toggles.
- Reset asserted mid-period: outputs go to 0 asynchronously; the counter restarts from 0.

Optional Feature:
- Macro: SLEW_LIMIT_EN.
- Defined: at each boundary, spd_q moves toward the command by at most SLEW_STEP (signed arithmetic, 13-bit intermediate, result clipped to -2048..2047). It lands exactly on the command when within SLEW_STEP.
  - Direction is taken from the sign of the slewed spd_q, so a reversal ramps down through 0 before the dead period.
  - en low still clears spd_q immediately; the ramp restarts from 0.
- Undefined: spd_q loads the command directly at each boundary. SLEW_STEP is unused.

Test Plan:
- Duty check: en=1, lft_spd=0x100 held. After the first boundary, PWM_lft_fwd is high for 256 of every 2048 cycles, PWM_lft_rev=0, and period_done pulses every 2048 cycles.
- Saturation: rght_spd=0x800 (-2048). After the settle sequence FWD -> DEAD_R -> REV, PWM_rght_rev is high for 2047 of 2048 cycles and PWM_rght_fwd=0.
- Reversal: lft_spd switches 0x200 -> 0xE00 (-512) mid-period. Required sequence:
  - The current period finishes forward at 512/2048.
  - The next full period has both legs 0.
  - The following periods run rev at 512/2048.
  - fwd and rev are never both high in any cycle.
- Zero and en: lft_spd=0 gives both legs low with state held. Dropping en low while running gives all legs 0 from the next cycle. Raising en with lft_spd=0x040 gives 64/2048 from the first full period after the next boundary.
- Mid-period change: changing the command at cnt=1000 leaves the current period's duty unchanged; the new duty starts at cnt=0.
- SLEW_LIMIT_EN: step the command 0 -> 0x200. Latched mag must be 64, 128, ..., 512 over 8 periods. Then a step to -0x200 ramps down to 0, takes one dead period, then ramps in reverse.
